// File: rtl/regfile_port_ctrl_pkg.sv
// Shared constants and the operand bundle type for the register-file port controller.
package regfile_port_ctrl_pkg;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int NREG = 16;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [AW-1:0] dst;
    logic          wen;
  } op_bundle_t;

  function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
    logic [AW:0] n;
    n = '0;
    for (int i = 0; i < NREG; i++) n = n + {{AW{1'b0}}, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking with set-over-clear priority, hazard lookups, occupancy count and stray-writeback flag.
module regfile_scoreboard
  import regfile_port_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          set_i,
  input  logic [AW-1:0] set_idx_i,
  input  logic          clr_i,
  input  logic [AW-1:0] clr_idx_i,
  input  logic [AW-1:0] q0_idx_i,
  input  logic [AW-1:0] q1_idx_i,
  input  logic [AW-1:0] q2_idx_i,
  output logic          q0_busy_o,
  output logic          q1_busy_o,
  output logic          q2_busy_o,
  output logic [AW:0]   pending_cnt_o,
  output logic          err_stray_o
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] clr_vec, ebusy;
  logic [AW:0]     cnt_q;
  logic            err_q;

  always_comb begin
    clr_vec = '0;
    if (clr_i) clr_vec[clr_idx_i] = 1'b1;
  end

  // A register being written back this cycle no longer blocks readers.
  assign ebusy     = busy_q & ~clr_vec;
  assign q0_busy_o = ebusy[q0_idx_i];
  assign q1_busy_o = ebusy[q1_idx_i];
  assign q2_busy_o = ebusy[q2_idx_i];

  // Clear applied first so a same-cycle set on the same register wins.
  always_comb begin
    busy_d = busy_q & ~clr_vec;
    if (set_i) busy_d[set_idx_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= popcount(busy_d);
      if (clr_i && !busy_q[clr_idx_i]) err_q <= 1'b1;
    end
  end

  assign pending_cnt_o = cnt_q;
  assign err_stray_o   = err_q;

endmodule

// File: rtl/regfile_port_ctrl.sv
// Pipeline-side port controller for the 16x8 register file: issue handshake, writeback bypass and operand register.
module regfile_port_ctrl
  import regfile_port_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          iss_valid,
  output logic          iss_ready,
  input  logic [AW-1:0] iss_src0,
  input  logic [AW-1:0] iss_src1,
  input  logic [AW-1:0] iss_dst,
  input  logic          iss_wen,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  output logic [AW-1:0] op_dst,
  output logic          op_wen,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_dst,
  input  logic [DW-1:0] wb_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_dst,
  output logic [DW-1:0] rf_data,
  output logic [AW-1:0] rf_src0,
  output logic [AW-1:0] rf_src1,
  input  logic [DW-1:0] rf_data0,
  input  logic [DW-1:0] rf_data1,
  output logic [AW:0]   pending_cnt,
  output logic          err_stray
);

  op_bundle_t op_q, op_d;
  logic       op_valid_q, op_valid_d;
  logic       eb0, eb1, ebd;
  logic       hazard, accept;

  assign rf_we   = wb_valid & ~rst;
  assign rf_dst  = wb_dst;
  assign rf_data = wb_data;
  assign rf_src0 = iss_src0;
  assign rf_src1 = iss_src1;

  regfile_scoreboard u_sb (
    .clk           (clk),
    .rst           (rst),
    .set_i         (accept & iss_wen),
    .set_idx_i     (iss_dst),
    .clr_i         (wb_valid),
    .clr_idx_i     (wb_dst),
    .q0_idx_i      (iss_src0),
    .q1_idx_i      (iss_src1),
    .q2_idx_i      (iss_dst),
    .q0_busy_o     (eb0),
    .q1_busy_o     (eb1),
    .q2_busy_o     (ebd),
    .pending_cnt_o (pending_cnt),
    .err_stray_o   (err_stray)
  );

  assign hazard    = eb0 | eb1 | (iss_wen & ebd);
  assign iss_ready = ~rst & ~hazard & (~op_valid_q | op_ready);
  assign accept    = iss_valid & iss_ready;

  // Operands bypass the register file when the matching result lands this cycle.
  always_comb begin
    op_d       = op_q;
    op_valid_d = op_valid_q;
    if (accept) begin
      op_valid_d = 1'b1;
      op_d.a     = (wb_valid && wb_dst == iss_src0) ? wb_data : rf_data0;
      op_d.b     = (wb_valid && wb_dst == iss_src1) ? wb_data : rf_data1;
      op_d.dst   = iss_dst;
      op_d.wen   = iss_wen;
    end else if (op_ready) begin
      op_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid_q <= 1'b0;
      op_q       <= '0;
    end else begin
      op_valid_q <= op_valid_d;
      op_q       <= op_d;
    end
  end

  assign op_valid = op_valid_q;
  assign op_a     = op_q.a;
  assign op_b     = op_q.b;
  assign op_dst   = op_q.dst;
  assign op_wen   = op_q.wen;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural scoreboard model.
module tb_regfile_port_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       iss_valid, iss_ready, iss_wen;
  logic [3:0] iss_src0, iss_src1, iss_dst;
  logic       op_valid, op_ready, op_wen;
  logic [7:0] op_a, op_b;
  logic [3:0] op_dst;
  logic       wb_valid;
  logic [3:0] wb_dst;
  logic [7:0] wb_data;
  logic       rf_we;
  logic [3:0] rf_dst, rf_src0, rf_src1;
  logic [7:0] rf_data, rf_data0, rf_data1;
  logic [4:0] pending_cnt;
  logic       err_stray;

  always #5 clk = ~clk;

  regfile_port_ctrl dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_src0(iss_src0), .iss_src1(iss_src1),
    .iss_dst(iss_dst), .iss_wen(iss_wen),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_dst(op_dst), .op_wen(op_wen),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .rf_we(rf_we), .rf_dst(rf_dst), .rf_data(rf_data), .rf_src0(rf_src0), .rf_src1(rf_src1),
    .rf_data0(rf_data0), .rf_data1(rf_data1),
    .pending_cnt(pending_cnt), .err_stray(err_stray)
  );

  // The register file itself lives in the bench.
  logic [7:0] rf_mem [16];
  always @(posedge clk) if (rf_we) rf_mem[rf_dst] <= rf_data;
  assign rf_data0 = rf_mem[rf_src0];
  assign rf_data1 = rf_mem[rf_src1];

  // Reference model state.
  bit         m_busy [16];
  logic [7:0] m_rf   [16];
  logic       m_opv, m_opwen, m_err;
  logic [7:0] m_opa, m_opb;
  logic [3:0] m_opdst;

  int   nchk = 0, nfail = 0;
  logic obs_ready, obs_rfwe, exp_ready, exp_rfwe;

  function automatic int m_pending();
    int n = 0;
    for (int i = 0; i < 16; i++) n += m_busy[i];
    return n;
  endfunction

  function automatic bit m_blocks(input logic [3:0] r);
    return m_busy[r] && !(wb_valid && wb_dst == r);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_busy[i] = 0;
    m_opv = 0; m_opa = 0; m_opb = 0; m_opdst = 0; m_opwen = 0; m_err = 0;
  endtask

  // Advance one clock: sample combinational outputs, step the model, then settle after the edge.
  task automatic tick();
    bit acc;
    #1;
    obs_ready = iss_ready;
    obs_rfwe  = rf_we;
    exp_rfwe  = wb_valid && !rst;
    exp_ready = !rst && !m_blocks(iss_src0) && !m_blocks(iss_src1) &&
                !(iss_wen && m_blocks(iss_dst)) && (!m_opv || op_ready);
    if (rst) m_reset();
    else begin
      acc = iss_valid && exp_ready;
      if (acc) begin
        m_opv   = 1;
        m_opa   = (wb_valid && wb_dst == iss_src0) ? wb_data : m_rf[iss_src0];
        m_opb   = (wb_valid && wb_dst == iss_src1) ? wb_data : m_rf[iss_src1];
        m_opdst = iss_dst;
        m_opwen = iss_wen;
      end else if (op_ready) m_opv = 0;
      if (wb_valid) begin
        if (!m_busy[wb_dst]) m_err = 1;
        m_busy[wb_dst] = 0;
        m_rf[wb_dst]   = wb_data;
      end
      if (acc && iss_wen) m_busy[iss_dst] = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [3:0] d, input logic w);
    iss_valid = v; iss_src0 = s0; iss_src1 = s1; iss_dst = d; iss_wen = w;
  endtask

  task automatic test_reset();
    rst = 1; wb_valid = 1; wb_dst = 2; wb_data = 8'hEE; issue(1, 0, 0, 1, 1); op_ready = 1;
    tick();
    nchk++; if (obs_ready !== 1'b0) begin nfail++; $display("FAIL reset_ready got=%b exp=0", obs_ready); end
    nchk++; if (obs_rfwe !== 1'b0) begin nfail++; $display("FAIL reset_rfwe got=%b exp=0", obs_rfwe); end
    nchk++;
    if ({op_valid, op_a, op_b, op_dst, op_wen, pending_cnt, err_stray} !== 28'h0) begin
      nfail++;
      $display("FAIL reset_state got v=%b a=%h b=%h d=%h w=%b pc=%0d err=%b exp all zero",
               op_valid, op_a, op_b, op_dst, op_wen, pending_cnt, err_stray);
    end
    wb_valid = 0; issue(0, 0, 0, 0, 0);
  endtask

  task automatic test_basic();
    rst = 0; issue(0, 0, 0, 0, 0);
    wb_valid = 1; wb_dst = 3; wb_data = 8'h2A; tick();
    wb_dst = 5; wb_data = 8'h11; tick();
    wb_valid = 0; tick();
    nchk++; if (err_stray !== 1'b1) begin nfail++; $display("FAIL preload_err got=%b exp=1", err_stray); end
    rst = 1; tick(); rst = 0;
    issue(1, 3, 5, 7, 1); tick();
    nchk++; if (obs_ready !== 1'b1) begin nfail++; $display("FAIL basic_ready got=%b exp=1", obs_ready); end
    nchk++;
    if ({op_valid, op_a, op_b, op_dst, op_wen} !== {1'b1, 8'h2A, 8'h11, 4'd7, 1'b1}) begin
      nfail++;
      $display("FAIL basic_bundle got v=%b a=%h b=%h d=%0d w=%b exp v=1 a=2a b=11 d=7 w=1",
               op_valid, op_a, op_b, op_dst, op_wen);
    end
    nchk++; if (pending_cnt !== 5'd1) begin nfail++; $display("FAIL basic_pending got=%0d exp=1", pending_cnt); end
  endtask

  task automatic test_raw();
    issue(1, 7, 0, 8, 1); tick();
    nchk++; if (obs_ready !== 1'b0) begin nfail++; $display("FAIL raw_stall got=%b exp=0", obs_ready); end
    wb_valid = 1; wb_dst = 7; wb_data = 8'h99; tick();
    wb_valid = 0;
    nchk++; if (obs_ready !== 1'b1) begin nfail++; $display("FAIL raw_release got=%b exp=1", obs_ready); end
    nchk++; if (op_a !== 8'h99) begin nfail++; $display("FAIL raw_bypass got=%h exp=99", op_a); end
    nchk++; if (pending_cnt !== 5'd1) begin nfail++; $display("FAIL raw_pending got=%0d exp=1", pending_cnt); end
  endtask

  task automatic test_waw();
    issue(1, 0, 0, 4, 1); tick();
    issue(1, 1, 1, 4, 1); tick();
    nchk++; if (obs_ready !== 1'b0) begin nfail++; $display("FAIL waw_stall got=%b exp=0", obs_ready); end
    wb_valid = 1; wb_dst = 4; wb_data = 8'h44; tick();
    wb_valid = 0; issue(0, 0, 0, 0, 0);
    nchk++; if (obs_ready !== 1'b1) begin nfail++; $display("FAIL waw_accept got=%b exp=1", obs_ready); end
    tick();
    nchk++; if (pending_cnt !== 5'd2) begin nfail++; $display("FAIL waw_setwins got=%0d exp=2", pending_cnt); end
    issue(1, 4, 0, 0, 0); tick();
    nchk++; if (obs_ready !== 1'b0) begin nfail++; $display("FAIL waw_still_busy got=%b exp=0", obs_ready); end
  endtask

  task automatic test_backpressure();
    logic [21:0] snap;
    op_ready = 0; issue(1, 1, 2, 10, 0); tick();
    nchk++; if (obs_ready !== 1'b1) begin nfail++; $display("FAIL bp_first got=%b exp=1", obs_ready); end
    snap = {op_a, op_b, op_dst, op_wen, op_valid};
    issue(1, 3, 5, 11, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      nchk++; if (obs_ready !== 1'b0) begin nfail++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, obs_ready); end
      nchk++;
      if ({op_a, op_b, op_dst, op_wen, op_valid} !== snap || op_valid !== 1'b1) begin
        nfail++; $display("FAIL bp_hold[%0d] got=%h exp=%h", i, {op_a, op_b, op_dst, op_wen, op_valid}, snap);
      end
    end
    op_ready = 1; tick();
    nchk++; if (obs_ready !== 1'b1) begin nfail++; $display("FAIL bp_release got=%b exp=1", obs_ready); end
    nchk++;
    if ({op_valid, op_a, op_b, op_dst} !== {1'b1, 8'h2A, 8'h11, 4'd11}) begin
      nfail++; $display("FAIL bp_next got v=%b a=%h b=%h d=%0d exp v=1 a=2a b=11 d=11", op_valid, op_a, op_b, op_dst);
    end
    issue(0, 0, 0, 0, 0);
  endtask

  task automatic test_stray();
    nchk++; if (err_stray !== 1'b0) begin nfail++; $display("FAIL stray_pre got=%b exp=0", err_stray); end
    wb_valid = 1; wb_dst = 9; wb_data = 8'h5A; tick();
    wb_valid = 0;
    nchk++; if (obs_rfwe !== 1'b1) begin nfail++; $display("FAIL stray_rfwe got=%b exp=1", obs_rfwe); end
    for (int i = 0; i < 3; i++) begin
      tick();
      nchk++; if (err_stray !== 1'b1) begin nfail++; $display("FAIL stray_sticky[%0d] got=%b exp=1", i, err_stray); end
    end
    rst = 1; tick(); rst = 0;
    nchk++; if (err_stray !== 1'b0) begin nfail++; $display("FAIL stray_clear got=%b exp=0", err_stray); end
  endtask

  task automatic test_fill();
    op_ready = 1;
    for (int i = 0; i < 16; i++) begin
      issue(1, 4'(i), 4'(i), 4'(i), 1); tick();
      nchk++; if (obs_ready !== 1'b1) begin nfail++; $display("FAIL fill_issue[%0d] got=%b exp=1", i, obs_ready); end
    end
    nchk++; if (pending_cnt !== 5'd16) begin nfail++; $display("FAIL fill_pending got=%0d exp=16", pending_cnt); end
    issue(1, 2, 6, 0, 0); tick();
    nchk++; if (obs_ready !== 1'b0) begin nfail++; $display("FAIL fill_blocked got=%b exp=0", obs_ready); end
    rst = 1; tick(); rst = 0; issue(0, 0, 0, 0, 0);
    #1;
    nchk++;
    if ({pending_cnt, op_valid, iss_ready} !== {5'd0, 1'b0, 1'b1}) begin
      nfail++; $display("FAIL fill_reset got pc=%0d v=%b rdy=%b exp pc=0 v=0 rdy=1", pending_cnt, op_valid, iss_ready);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(63) == 0);
      issue($urandom_range(3) != 0, 4'($urandom_range(15)), 4'($urandom_range(15)),
            4'($urandom_range(15)), $urandom_range(1));
      op_ready = ($urandom_range(3) != 0);
      wb_dst   = 4'($urandom_range(15));
      wb_data  = 8'($urandom);
      wb_valid = m_busy[wb_dst] ? ($urandom_range(1) == 1) : ($urandom_range(15) == 0);
      tick();
      nchk++;
      if ({obs_ready, obs_rfwe} !== {exp_ready, exp_rfwe}) begin
        nfail++; $display("FAIL rnd_comb[%0d] got rdy=%b we=%b exp rdy=%b we=%b", n, obs_ready, obs_rfwe, exp_ready, exp_rfwe);
      end
      nchk++;
      if (op_valid !== m_opv || (m_opv && {op_a, op_b, op_dst, op_wen} !== {m_opa, m_opb, m_opdst, m_opwen})) begin
        nfail++;
        $display("FAIL rnd_bundle[%0d] got v=%b a=%h b=%h d=%0d w=%b exp v=%b a=%h b=%h d=%0d w=%b", n,
                 op_valid, op_a, op_b, op_dst, op_wen, m_opv, m_opa, m_opb, m_opdst, m_opwen);
      end
      nchk++;
      if ({pending_cnt, err_stray} !== {5'(m_pending()), m_err}) begin
        nfail++; $display("FAIL rnd_sb[%0d] got pc=%0d err=%b exp pc=%0d err=%b", n, pending_cnt, err_stray, m_pending(), m_err);
      end
    end
    rst = 0; wb_valid = 0; issue(0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin rf_mem[i] = 8'h00; m_rf[i] = 8'h00; end
    m_reset();
    rst = 1; op_ready = 1; wb_valid = 0; wb_dst = 0; wb_data = 0; issue(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_raw();
    test_waw();
    test_backpressure();
    test_stray();
    test_fill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/regfile_port_ctrl.md
Name: regfile_port_ctrl

Overview:
Drives the 16x8 CPU register file from the pipeline side. It accepts issued instructions (src0/src1/dst) over a valid/ready handshake and presents the registered operands to the execute stage. It also steers execute results back as register writes. A per-register busy scoreboard stalls read-after-write and write-after-write hazards, and a writeback bypass forwards same-cycle results.

Parameters:
DW, 8, data width of each register
AW, 4, register index width
NREG, 16, number of registers (equals 2**AW)

Ports:
clk  in  1  clock
rst  in  1  reset
iss_valid  in  1  instruction issue valid
iss_ready  out  1  issue accepted this cycle when high with iss_valid
iss_src0  in  AW  first source register index
iss_src1  in  AW  second source register index
iss_dst  in  AW  destination register index
iss_wen  in  1  instruction will write iss_dst
op_valid  out  1  operand bundle valid to execute
op_ready  in  1  execute accepts bundle
op_a  out  DW  operand from src0
op_b  out  DW  operand from src1
op_dst  out  AW  destination index carried with bundle
op_wen  out  1  write flag carried with bundle
wb_valid  in  1  execute result valid (always accepted)
wb_dst  in  AW  result destination index
wb_data  in  DW  result value
rf_we  out  1  register file write enable
rf_dst  out  AW  register file write index
rf_data  out  DW  register file write data
rf_src0  out  AW  register file read index 0
rf_src1  out  AW  register file read index 1
rf_data0  in  DW  register file read data 0 (combinational)
rf_data1  in  DW  register file read data 1 (combinational)
pending_cnt  out  AW+1  number of busy registers
err_stray  out  1  sticky: writeback to a non-busy register

Behaviour:
- Reset rst, synchronous, active-high; clock clk. On reset: busy[] = 0, op_valid = 0, op_a = op_b = 0, op_dst = 0, op_wen = 0, pending_cnt = 0, err_stray = 0.
- rf_we = wb_valid & ~rst. rf_dst = wb_dst, rf_data = wb_data, rf_src0 = iss_src0, rf_src1 = iss_src1, all combinational.
- clr[r] = wb_valid & (wb_dst == r).
- Effective busy: ebusy[r] = busy[r] & ~clr[r].
- hazard = ebusy[iss_src0] | ebusy[iss_src1] | (iss_wen & ebusy[iss_dst]).
- iss_ready = ~rst & ~hazard & (~op_valid | op_ready). Combinational; it must not depend on iss_valid.
- Operand select (bypass): op_a_next = (wb_valid & wb_dst == iss_src0) ? wb_data : rf_data0. op_b_next uses src1 and rf_data1 the same way.
- On accept (iss_valid & iss_ready) at edge N:
  - op_valid = 1 from cycle N+1, with op_a/op_b/op_dst/op_wen latched.
  - If iss_wen, busy[iss_dst] is set. Latency issue-to-operand is 1 cycle.
- If op_valid & op_ready and there is no new accept, op_valid drops to 0. The bundle holds stable while op_valid & ~op_ready.
- Writeback clears busy[wb_dst]. If the same register is set by an accept and cleared by a writeback in one cycle, set wins.
- A writeback with busy[wb_dst] = 0 is still written to the register file and sets err_stray (sticky until reset).
- pending_cnt = popcount(busy), registered. It ranges 0..NREG and never wraps.
- src0 == src1 is legal; the same value is read on both ports.
- If iss_dst equals a source and iss_wen is set, the read uses the pre-instruction value. The busy set does not self-stall.
- Reset mid-operation: the scoreboard and op bundle are discarded. Writebacks arriving while rst is high are dropped (rf_we = 0).

Decomposition:
- Shared package: DW, AW, NREG constants; an operand-bundle struct {a, b, dst, wen}.
- One natural sub-module, regfile_scoreboard: holds the busy vector, set/clear priority, ebusy lookup for three indices, pending_cnt and err_stray.
- Handshake, bypass muxes and the op register stay in the top.

Test Plan:
1. Reset, preload R3=0x2A and R5=0x11 via writebacks (err_stray=1, then reset again), issue src0=3 src1=5 dst=7 wen=1 -> next cycle op_a=0x2A, op_b=0x11, op_dst=7, busy[7]=1, pending_cnt=1.
2. RAW: with R7 busy, issue src0=7 -> iss_ready=0. Apply wb_dst=7 wb_data=0x99 in the same cycle -> iss_ready=1, op_a=0x99 (bypass), pending_cnt unchanged net (cleared 7).
3. WAW: R4 busy, issue dst=4 wen=1 with no writeback -> stalls. Writeback to 4 in the same cycle -> accepted, busy[4] stays 1 (set wins).
4. Back-pressure: op_ready=0 with op_valid=1 -> iss_ready=0 and op bundle stable for 5 cycles. Raise op_ready -> next issue accepted that cycle.
5. Stray writeback: wb_dst=9 with busy[9]=0 -> rf_we=1 and err_stray=1 stays high until rst.
6. Fill: issue 16 writes dst=0..15 -> pending_cnt=16, every issue blocked. Assert rst for 1 cycle -> pending_cnt=0, op_valid=0, iss_ready=1.
